// File: rtl/gbdmg_vgm_pkg.sv
// Shared constants and state types for the VGM command player that feeds the DMG APU.
package gbdmg_vgm_pkg;

    localparam logic [7:0] OP_GB_WR     = 8'hB3;
    localparam logic [7:0] OP_WAIT16    = 8'h61;
    localparam logic [7:0] OP_WAIT_NTSC = 8'h62;
    localparam logic [7:0] OP_WAIT_PAL  = 8'h63;
    localparam logic [7:0] OP_END       = 8'h66;
    // 0x70-0x7F: short wait of (low nibble + 1) samples
    localparam logic [3:0] OP_WAIT_SHORT = 4'h7;

    localparam logic [15:0] WAIT_NTSC_TICKS = 16'd735;
    localparam logic [15:0] WAIT_PAL_TICKS  = 16'd882;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH_OP,
        ST_FETCH_A,
        ST_FETCH_D,
        ST_FETCH_W0,
        ST_FETCH_W1,
        ST_WR_HI,
        ST_WR_LO,
        ST_WAIT,
        ST_DONE,
        ST_ERROR
    } vgm_state_e;

    typedef enum logic [1:0] {
        SP_IDLE,
        SP_HI,
        SP_LO
    } strb_phase_e;

endpackage

// File: rtl/gbdmg_wr_strobe.sv
// Shapes one APU register write into WR_HOLD high cycles followed by WR_GAP low cycles.
module gbdmg_wr_strobe #(
    parameter int WR_HOLD = 2,
    parameter int WR_GAP  = 2
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic in_start,
    output logic out_wr,
    output logic out_hi_done,
    output logic out_done
);
    import gbdmg_vgm_pkg::*;

    strb_phase_e phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hi_last, lo_last;

    assign hi_last = (phase_q == SP_HI) && (cnt_q == 8'(WR_HOLD - 1));
    assign lo_last = (phase_q == SP_LO) && (cnt_q == 8'(WR_GAP - 1));

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            phase_q <= SP_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (in_start) begin
            phase_d = SP_HI;
            cnt_d   = 8'd0;
        end else begin
            case (phase_q)
                SP_HI: begin
                    if (hi_last) begin
                        phase_d = SP_LO;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                SP_LO: begin
                    if (lo_last) begin
                        phase_d = SP_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    phase_d = SP_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Decoded straight from the phase register so reset clears the strobe at once.
    assign out_wr      = (phase_q == SP_HI);
    assign out_hi_done = hi_last;
    assign out_done    = lo_last;

endmodule

// File: rtl/gbdmg_vgm_player.sv
// Walks a VGM byte stream, issuing DMG register writes and pacing waits on the sample tick.
module gbdmg_vgm_player #(
    parameter int WR_HOLD = 2,
    parameter int WR_GAP  = 2
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       out_ready,
    input  logic       in_sample_tick,
    output logic [5:0] out_reg,
    output logic [7:0] out_val,
    output logic       out_wr,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_error
);
    import gbdmg_vgm_pkg::*;

    vgm_state_e  state_q, state_d;
    logic        accept;
    logic [7:0]  aa_q, wlo_q;
    logic [15:0] cnt_q, cnt_load;
    logic        load_cnt;
    logic [15:0] wait16;
    logic [5:0]  reg_q;
    logic [7:0]  val_q;
    logic        strb_start, strb_hi_done, strb_done;

    assign accept     = in_valid && out_ready;
    assign wait16     = {in_data, wlo_q};
    assign strb_start = (state_q == ST_FETCH_D) && accept && (aa_q[7:6] == 2'b00);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load_cnt = 1'b0;
        cnt_load = 16'd0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (in_start) state_d = ST_FETCH_OP;
            end
            ST_FETCH_OP: begin
                if (accept) begin
                    if (in_data[7:4] == OP_WAIT_SHORT) begin
                        state_d  = ST_WAIT;
                        load_cnt = 1'b1;
                        cnt_load = {12'd0, in_data[3:0]} + 16'd1;
                    end else begin
                        case (in_data)
                            OP_GB_WR:     state_d = ST_FETCH_A;
                            OP_WAIT16:    state_d = ST_FETCH_W0;
                            OP_WAIT_NTSC: begin
                                state_d  = ST_WAIT;
                                load_cnt = 1'b1;
                                cnt_load = WAIT_NTSC_TICKS;
                            end
                            OP_WAIT_PAL: begin
                                state_d  = ST_WAIT;
                                load_cnt = 1'b1;
                                cnt_load = WAIT_PAL_TICKS;
                            end
                            OP_END:       state_d = ST_DONE;
                            default:      state_d = ST_ERROR;
                        endcase
                    end
                end
            end
            ST_FETCH_A:  if (accept) state_d = ST_FETCH_D;
            ST_FETCH_D: begin
                // Addresses above 0x3F are outside the APU window and are skipped.
                if (accept) state_d = (aa_q[7:6] == 2'b00) ? ST_WR_HI : ST_FETCH_OP;
            end
            ST_FETCH_W0: if (accept) state_d = ST_FETCH_W1;
            ST_FETCH_W1: begin
                if (accept) begin
                    if (wait16 == 16'd0) begin
                        state_d = ST_FETCH_OP;
                    end else begin
                        state_d  = ST_WAIT;
                        load_cnt = 1'b1;
                        cnt_load = wait16;
                    end
                end
            end
            ST_WR_HI: if (strb_hi_done) state_d = ST_WR_LO;
            ST_WR_LO: if (strb_done) state_d = ST_FETCH_OP;
            ST_WAIT: begin
                if (in_sample_tick && (cnt_q == 16'd1)) state_d = ST_FETCH_OP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            aa_q  <= 8'd0;
            wlo_q <= 8'd0;
            cnt_q <= 16'd0;
            reg_q <= 6'd0;
            val_q <= 8'd0;
        end else begin
            if ((state_q == ST_FETCH_A) && accept)  aa_q  <= in_data;
            if ((state_q == ST_FETCH_W0) && accept) wlo_q <= in_data;
            if (strb_start) begin
                reg_q <= aa_q[5:0];
                val_q <= in_data;
            end
            // Ticks only count while waiting; the load cycle is never in WAIT.
            if (load_cnt)
                cnt_q <= cnt_load;
            else if ((state_q == ST_WAIT) && in_sample_tick && (cnt_q != 16'd0))
                cnt_q <= cnt_q - 16'd1;
        end
    end

    gbdmg_wr_strobe #(
        .WR_HOLD (WR_HOLD),
        .WR_GAP  (WR_GAP)
    ) u_wr_strobe (
        .in_clk      (in_clk),
        .in_rst_n    (in_rst_n),
        .in_start    (strb_start),
        .out_wr      (out_wr),
        .out_hi_done (strb_hi_done),
        .out_done    (strb_done)
    );

    always_comb begin
        out_ready = 1'b0;
        out_busy  = 1'b1;
        case (state_q)
            ST_FETCH_OP, ST_FETCH_A, ST_FETCH_D, ST_FETCH_W0, ST_FETCH_W1: out_ready = 1'b1;
            ST_IDLE, ST_DONE, ST_ERROR: out_busy = 1'b0;
            default: ;
        endcase
    end

    assign out_done  = (state_q == ST_DONE);
    assign out_error = (state_q == ST_ERROR);
    assign out_reg   = reg_q;
    assign out_val   = val_q;

endmodule

// File: tb/tb_gbdmg_vgm_player.sv
// Randomized bench for gbdmg_vgm_player: a stream-level model predicts writes, waits and final status.
module tb_gbdmg_vgm_player;
    localparam int WR_HOLD = 2;
    localparam int WR_GAP  = 2;

    logic       in_clk = 1'b0;
    logic       in_rst_n = 1'b0;
    logic       in_start = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_sample_tick = 1'b0;
    logic       out_ready, out_wr, out_busy, out_done, out_error;
    logic [5:0] out_reg;
    logic [7:0] out_val;

    always #5 in_clk = ~in_clk;

    gbdmg_vgm_player #(.WR_HOLD(WR_HOLD), .WR_GAP(WR_GAP)) dut (
        .in_clk         (in_clk),
        .in_rst_n       (in_rst_n),
        .in_start       (in_start),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_sample_tick (in_sample_tick),
        .out_reg        (out_reg),
        .out_val        (out_val),
        .out_wr         (out_wr),
        .out_busy       (out_busy),
        .out_done       (out_done),
        .out_error      (out_error)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0]  stream_q[$];
    logic [13:0] exp_q[$];       // {reg, val} of each write the stream must produce
    logic [15:0] exp_wait_q[$];  // tick count of each wait that must be observed
    int          exp_remaining;
    logic        exp_err;

    int valid_pct   = 100;
    int tick_period = 0;
    bit start_req   = 0;
    bit rand_start  = 0;
    int cyc         = 0;

    logic prev_wr     = 1'b0;
    int   hi_len      = 0;
    int   low_run     = 100;
    logic in_wait_obs = 1'b0;
    int   tick_cnt    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stream-level reference: what the byte sequence means, independent of cycle timing.
    task automatic model();
        int i;
        logic [7:0] op, aa, dd;
        exp_q.delete();
        exp_wait_q.delete();
        exp_err = 1'b0;
        i = 0;
        while (i < stream_q.size()) begin
            op = stream_q[i];
            i++;
            if (op == 8'hB3) begin
                aa = stream_q[i];
                dd = stream_q[i+1];
                i += 2;
                if (aa < 8'h40) exp_q.push_back({aa[5:0], dd});
            end else if (op == 8'h61) begin
                if ((stream_q[i] != 8'd0) || (stream_q[i+1] != 8'd0))
                    exp_wait_q.push_back({stream_q[i+1], stream_q[i]});
                i += 2;
            end else if (op == 8'h62) begin
                exp_wait_q.push_back(16'd735);
            end else if (op == 8'h63) begin
                exp_wait_q.push_back(16'd882);
            end else if ((op >= 8'h70) && (op <= 8'h7F)) begin
                exp_wait_q.push_back(16'(op - 8'h70 + 8'd1));
            end else if (op == 8'h66) begin
                break;
            end else begin
                exp_err = 1'b1;
                break;
            end
        end
        exp_remaining = stream_q.size() - i;
    endtask

    task automatic monitor();
        logic [13:0] e;
        logic now_wait;
        if (out_wr && !prev_wr) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_reg", 32'(out_reg), 32'(e[13:8]));
                check("wr_val", 32'(out_val), 32'(e[7:0]));
            end
            hi_len = 1;
        end else if (out_wr) begin
            hi_len++;
        end
        if (out_wr) check("rdy_in_wr", 32'(out_ready), 32'd0);
        if (!out_wr && prev_wr) check("wr_hold", hi_len, WR_HOLD);
        low_run = out_wr ? 0 : ((low_run < 100) ? low_run + 1 : low_run);
        // Busy, not fetching, strobe low and past the write gap: the player is waiting.
        now_wait = out_busy && !out_ready && !out_wr && (low_run > WR_GAP);
        if (now_wait && !in_wait_obs) tick_cnt = 0;
        if (!now_wait && in_wait_obs) begin
            if (exp_wait_q.size() == 0) check("wait_unexpected", 32'd1, 32'd0);
            else check("wait_ticks", tick_cnt, 32'(exp_wait_q.pop_front()));
        end
        in_wait_obs = now_wait;
        prev_wr     = out_wr;
    endtask

    task automatic drive();
        logic tick, v;
        in_start = start_req || (rand_start && out_busy && ($urandom_range(0, 49) == 0));
        start_req = 0;
        tick = (tick_period > 0) ? ((cyc % tick_period) == 0) : 1'($urandom_range(0, 1));
        in_sample_tick = tick;
        if (tick && in_wait_obs) tick_cnt++;
        v = (stream_q.size() > 0) && ($urandom_range(1, 100) <= valid_pct);
        in_valid = v;
        in_data  = v ? stream_q[0] : 8'($urandom);
        if (v && out_ready) void'(stream_q.pop_front());
        cyc++;
    endtask

    task automatic step();
        @(negedge in_clk);
        monitor();
        drive();
    endtask

    task automatic reset_now();
        int viol;
        #2 in_rst_n = 1'b0;
        #1;
        check("rst_wr", 32'(out_wr), 32'd0);
        check("rst_busy", 32'(out_busy), 32'd0);
        check("rst_ready", 32'(out_ready), 32'd0);
        check("rst_reg", 32'(out_reg), 32'd0);
        check("rst_val", 32'(out_val), 32'd0);
        in_start = 1'b0;
        @(negedge in_clk);
        in_rst_n = 1'b1;
        stream_q.delete();
        exp_q.delete();
        exp_wait_q.delete();
        prev_wr = 1'b0;
        low_run = 100;
        in_wait_obs = 1'b0;
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data = 8'hB3;
            in_sample_tick = 1'($urandom_range(0, 1));
            @(negedge in_clk);
            if (out_busy || out_ready || out_wr || out_done || out_error) viol++;
        end
        in_valid = 1'b0;
        check("idle_after_rst", viol, 0);
    endtask

    // abort_mode: 0 run to end, 1 reset during first strobe, 2 reset after 3 ticks of a wait
    task automatic run(input int abort_mode);
        bit finished;
        model();
        start_req = 1;
        step();
        finished = 0;
        for (int c = 0; c < 40000; c++) begin
            step();
            if ((abort_mode == 1) && out_wr) begin
                reset_now();
                return;
            end
            if ((abort_mode == 2) && in_wait_obs && (tick_cnt >= 3)) begin
                reset_now();
                return;
            end
            if (out_done || out_error) begin
                finished = 1;
                break;
            end
        end
        in_valid = 1'b0;
        check("finished", 32'(finished), 32'd1);
        check("end_done", 32'(out_done), 32'(!exp_err));
        check("end_error", 32'(out_error), 32'(exp_err));
        check("end_ready", 32'(out_ready), 32'd0);
        check("end_busy", 32'(out_busy), 32'd0);
        check("writes_left", exp_q.size(), 0);
        check("waits_left", exp_wait_q.size(), 0);
        check("bytes_left", stream_q.size(), exp_remaining);
    endtask

    task automatic gen_random_stream();
        int n, r;
        stream_q.delete();
        n = $urandom_range(3, 10);
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 11);
            if (r <= 4) begin
                stream_q.push_back(8'hB3);
                stream_q.push_back(8'($urandom_range(0, 63)));
                stream_q.push_back(8'($urandom));
            end else if (r == 5) begin
                stream_q.push_back(8'hB3);
                stream_q.push_back(8'($urandom_range(64, 255)));
                stream_q.push_back(8'($urandom));
            end else if (r == 6) begin
                stream_q.push_back(8'h61);
                stream_q.push_back(8'($urandom_range(0, 12)));
                stream_q.push_back(8'h00);
            end else if (r == 7) begin
                stream_q.push_back(8'h61);
                stream_q.push_back(8'h00);
                stream_q.push_back(8'h00);
            end else if (r <= 9) begin
                stream_q.push_back(8'(8'h70 + $urandom_range(0, 15)));
            end else if (r == 10) begin
                stream_q.push_back(8'h61);
                stream_q.push_back(8'h05);
                stream_q.push_back(8'h01);
            end else begin
                stream_q.push_back(($urandom_range(0, 3) == 0) ? 8'h50 : 8'hB3);
                stream_q.push_back(8'($urandom_range(0, 63)));
                stream_q.push_back(8'($urandom));
            end
        end
        stream_q.push_back(8'h66);
    endtask

    initial begin
        repeat (3) @(negedge in_clk);
        check("init_ready", 32'(out_ready), 32'd0);
        check("init_wr", 32'(out_wr), 32'd0);
        check("init_reg", 32'(out_reg), 32'd0);
        check("init_val", 32'(out_val), 32'd0);
        check("init_busy", 32'(out_busy), 32'd0);
        check("init_done", 32'(out_done), 32'd0);
        check("init_error", 32'(out_error), 32'd0);
        in_rst_n = 1'b1;
        @(negedge in_clk);

        stream_q = '{8'hB3, 8'h12, 8'h80, 8'h66};
        run(0);

        tick_period = 10;
        stream_q = '{8'h61, 8'h03, 8'h00, 8'hB3, 8'h01, 8'h55, 8'h66};
        run(0);
        tick_period = 0;

        stream_q = '{8'h61, 8'h00, 8'h00, 8'hB3, 8'h07, 8'h33, 8'h66};
        run(0);
        stream_q = '{8'h62, 8'h73, 8'h66};
        run(0);
        stream_q = '{8'h63, 8'h70, 8'h7F, 8'h66};
        run(0);

        valid_pct = 50;
        stream_q = '{8'hB3, 8'h02, 8'hAA, 8'h66};
        run(0);
        valid_pct = 100;

        stream_q = '{8'hB3, 8'h45, 8'hFF, 8'hB3, 8'h3F, 8'h01, 8'h66};
        run(0);

        stream_q = '{8'h50, 8'hB3, 8'h09, 8'h09, 8'h66};
        run(0);
        stream_q = '{8'hB3, 8'h04, 8'h87, 8'h66};
        run(0);

        rand_start = 1;
        for (int t = 0; t < 25; t++) begin
            valid_pct = $urandom_range(30, 100);
            gen_random_stream();
            run(0);
        end
        rand_start = 0;
        valid_pct = 100;

        stream_q = '{8'hB3, 8'h10, 8'h20, 8'h66};
        run(1);
        stream_q = '{8'h62, 8'h66};
        run(2);
        stream_q = '{8'hB3, 8'h05, 8'h06, 8'h66};
        run(0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
